l1d_line_responder: RTL and testbench
=====================================

// Module: l1d_line_responder
// PURPOSE
//  Responder end of the pipeline data-memory interface (mem_read/mem_write/mem_address/line_offset ->
//  mem_resp/mem_rdata) driven by the MEM-stage stall/LDI-STI sequencer. Direct-mapped, write-through,
//  no-write-allocate line cache. Refills 128-bit lines from, and writes through to, the physical-memory
//  arbiter port. Issues exactly one mem_resp pulse per completed access.
// PARAMETERS
//  NUM_LINES  8  cache lines, power of two, 2..64; IDX_W=$clog2(NUM_LINES), TAG_W=12-IDX_W
// PORTS
//  clk              in   1    clock, all state on posedge
//  reset_n          in   1    synchronous reset, active low
//  mem_read         in   1    word read request, held until mem_resp
//  mem_write        in   1    word write request, held until mem_resp
//  mem_address      in   12   line address (lc3b_wb_adr); idx=[IDX_W-1:0], tag=[11:IDX_W]
//  line_offset      in   4    byte offset in line; [3:1] selects word, [0] ignored
//  mem_byte_enable  in   2    write byte lanes {hi,lo}; ignored on reads
//  mem_wdata        in   16   write data
//  mem_rdata        out  16   read data, valid while mem_resp=1
//  mem_resp         out  1    access complete, one-cycle pulse
//  pmem_read        out  1    line refill request
//  pmem_write       out  1    write-through request
//  pmem_address     out  12   line address to arbiter = mem_address
//  pmem_wdata       out  128  mem_wdata replicated into all 8 word slots
//  pmem_byte_sel    out  16   byte strobes; bits {2w+1,2w} = mem_byte_enable, w=line_offset[3:1]
//  pmem_rdata       in   128  refill data, valid with pmem_resp
//  pmem_resp        in   1    arbiter completion, one-cycle pulse
// BEHAVIOUR
//  Reset: all valid bits cleared, state IDLE. mem_resp=0, pmem_read=0, pmem_write=0, pmem_byte_sel=0,
//   mem_rdata=0. Data/tag arrays are not reset.
//  Reset mid-operation: the in-flight pmem access is dropped immediately; no mem_resp; no array update.
//  FSM IDLE:
//   - mem_write (has priority if both requests are asserted) -> WRITE.
//   - mem_read: hit (valid[idx] && tag match) -> mem_resp=1 combinationally, same cycle, zero wait;
//     mem_rdata = word w of line idx; stay IDLE.
//   - mem_read miss -> FILL.
//  FILL: pmem_read=1 until pmem_resp. On pmem_resp: write line and tag, set valid -> IDLE. The read
//   then hits in the next cycle. Read miss latency = arbiter latency + 1 cycle. No mem_resp in FILL.
//  WRITE: pmem_write=1 with pmem_address, pmem_wdata, pmem_byte_sel until pmem_resp.
//   On pmem_resp: mem_resp=1 (same cycle); if hit, merge enabled bytes into the cached word -> IDLE.
//   Write miss leaves the cache unchanged (no allocate).
//  mem_resp is never high in two consecutive cycles for one access. A request still asserted in the
//   cycle after mem_resp is treated as a new access; re-reading is harmless.
//  Requests deasserted mid-FILL: the fill completes and the line is installed. Mid-WRITE is illegal.
//  Outputs outside the active state: pmem_read=0, pmem_write=0, pmem_byte_sel=0.
//  mem_rdata: 0 when mem_resp=0.
// CONFIGURATION
//  L1D_PERF_COUNTERS_EN defined: adds ports hit_count and miss_count (out, 16 each).
//   - Saturating counters, cleared by reset.
//   - +1 per read hit mem_resp, +1 per FILL entry.
//   - Writes are not counted.
//  Not defined: ports and counters are absent; behaviour otherwise identical.
// TESTING
//  Reset: hold reset_n=0 3 cycles -> all outputs 0; read 0x012/off 4 misses (pmem_read=1 next cycle).
//  Read miss: 0x012 off 4, pmem_rdata word2=16'hBEEF, pmem_resp after 5 cycles
//   -> one mem_resp pulse one cycle after pmem_resp, mem_rdata=16'hBEEF.
//  Read hit: repeat 0x012 off 4 -> mem_resp in the request cycle, no pmem_read.
//  Write hit: 0x012 off 4, be=2'b10, wdata=16'h1200 -> pmem_byte_sel=16'h0020; after pmem_resp,
//   read returns 16'h12EF.
//  Conflict (NUM_LINES=8): read 0x01A (idx 2) evicts 0x012 -> read 0x012 refills.
//  LDI pattern: back-to-back read miss then read hit to a different line -> exactly two mem_resp pulses.
//  Reset during FILL: reset_n=0 while pmem_read=1 -> pmem_read=0 next cycle, no mem_resp, line invalid.

Source files
------------

// File: rtl/l1d_line_responder_if.sv
// l1d_line_responder_if: pipeline-side word port plus arbiter-side line port of the L1D responder
interface l1d_line_responder_if;
  logic         mem_read;
  logic         mem_write;
  logic [11:0]  mem_address;
  logic [3:0]   line_offset;
  logic [1:0]   mem_byte_enable;
  logic [15:0]  mem_wdata;
  logic [15:0]  mem_rdata;
  logic         mem_resp;
  logic         pmem_read;
  logic         pmem_write;
  logic [11:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic [15:0]  pmem_byte_sel;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;
  modport master (
    output mem_read, mem_write, mem_address, line_offset, mem_byte_enable, mem_wdata,
    input  mem_rdata, mem_resp,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_byte_sel,
    output pmem_rdata, pmem_resp
  );
  modport slave (
    input  mem_read, mem_write, mem_address, line_offset, mem_byte_enable, mem_wdata,
    output mem_rdata, mem_resp,
    output pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_byte_sel,
    input  pmem_rdata, pmem_resp
  );
endinterface

// File: rtl/l1d_line_responder.sv
// l1d_line_responder: direct-mapped write-through no-allocate line cache; L1D_PERF_COUNTERS_EN adds hit/miss counters
module l1d_line_responder #(
  parameter int NUM_LINES = 8
) (
  input logic clk,
  input logic reset_n,
  l1d_line_responder_if.slave bus
`ifdef L1D_PERF_COUNTERS_EN
  ,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
`endif
);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = 12 - IDX_W;
  typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;
  state_t state_q, state_d;
  logic [NUM_LINES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0] tag_q [NUM_LINES];
  logic [TAG_W-1:0] tag_d [NUM_LINES];
  logic [127:0] data_q [NUM_LINES];
  logic [127:0] data_d [NUM_LINES];
  logic [11:0] addr_q, addr_d;
  logic [IDX_W-1:0] idx, fidx;
  logic [2:0] w;
  logic [15:0] sel;
  logic hit;
  logic unused_ok;
  assign idx = bus.mem_address[IDX_W-1:0];
  assign fidx = addr_q[IDX_W-1:0];
  assign w = bus.line_offset[3:1];
  assign hit = valid_q[idx] && tag_q[idx] == bus.mem_address[11:IDX_W];
  assign sel = 16'(bus.mem_byte_enable) << {w, 1'b0};
  assign bus.pmem_wdata = {8{bus.mem_wdata}};
  assign unused_ok = bus.line_offset[0];
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    tag_d = tag_q;
    data_d = data_q;
    addr_d = addr_q;
    bus.mem_resp = 1'b0;
    bus.mem_rdata = '0;
    bus.pmem_read = 1'b0;
    bus.pmem_write = 1'b0;
    bus.pmem_byte_sel = '0;
    bus.pmem_address = bus.mem_address;
    if (reset_n) begin
      case (state_q)
        IDLE: begin
          addr_d = bus.mem_address;
          if (bus.mem_write) state_d = WRITE;
          else if (bus.mem_read && hit) begin
            bus.mem_resp = 1'b1;
            bus.mem_rdata = data_q[idx][{w, 4'b0} +: 16];
          end else if (bus.mem_read) state_d = FILL;
        end
        // the fill address is latched so a dropped request still installs the right line
        FILL: begin
          bus.pmem_read = 1'b1;
          bus.pmem_address = addr_q;
          if (bus.pmem_resp) begin
            valid_d[fidx] = 1'b1;
            tag_d[fidx] = addr_q[11:IDX_W];
            data_d[fidx] = bus.pmem_rdata;
            state_d = IDLE;
          end
        end
        WRITE: begin
          bus.pmem_write = 1'b1;
          bus.pmem_byte_sel = sel;
          if (bus.pmem_resp) begin
            bus.mem_resp = 1'b1;
            if (hit)
              for (int i = 0; i < 16; i++)
                if (sel[i]) data_d[idx][8*i +: 8] = bus.pmem_wdata[8*i +: 8];
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      valid_q <= '0;
      addr_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      addr_q <= addr_d;
    end
  end
  always_ff @(posedge clk) begin
    tag_q <= tag_d;
    data_q <= data_d;
  end
`ifdef L1D_PERF_COUNTERS_EN
  logic [15:0] hit_q, hit_d, miss_q, miss_d;
  always_comb begin
    hit_d = (bus.mem_resp && state_q == IDLE && !(&hit_q)) ? hit_q + 16'd1 : hit_q;
    miss_d = (state_q == IDLE && state_d == FILL && !(&miss_q)) ? miss_q + 16'd1 : miss_q;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hit_q <= '0;
      miss_q <= '0;
    end else begin
      hit_q <= hit_d;
      miss_q <= miss_d;
    end
  end
  assign hit_count = hit_q;
  assign miss_count = miss_q;
`endif
endmodule

// File: tb/tb_l1d_line_responder.sv
// tb_l1d_line_responder: randomized accesses checked against a write-through memory model and a tag-only cache model
module tb_l1d_line_responder;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  l1d_line_responder_if b();
`ifdef L1D_PERF_COUNTERS_EN
  logic [15:0] hit_count, miss_count;
`endif
  l1d_line_responder #(.NUM_LINES(8)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(b)
`ifdef L1D_PERF_COUNTERS_EN
    ,
    .hit_count(hit_count),
    .miss_count(miss_count)
`endif
  );
  always #5 clk = ~clk;
  int checks = 0;
  int failures = 0;
  logic [127:0] mem [4096];
  logic [127:0] ref_mem [4096];
  logic mvalid [8];
  logic [8:0] mtag [8];
  int hits = 0, misses = 0;
  logic [15:0] exp_rd = '0, exp_sel = '0;
  logic pending = 1'b0, is_rd = 1'b0;
  int arb_lat = 1;
  int resp_seen = 0, resp_exp = 0;
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  // arbiter: answers the Nth cycle a request is seen, memory updated from the DUT's own strobes
  initial begin
    int cnt;
    cnt = 0;
    b.pmem_resp = 1'b0;
    b.pmem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      b.pmem_resp = 1'b0;
      if (!reset_n) cnt = 0;
      else if (b.pmem_read || b.pmem_write) begin
        cnt++;
        if (cnt >= arb_lat) begin
          cnt = 0;
          b.pmem_resp = 1'b1;
          if (b.pmem_read) b.pmem_rdata = mem[b.pmem_address];
          else
            for (int k = 0; k < 16; k++)
              if (b.pmem_byte_sel[k]) mem[b.pmem_address][8*k +: 8] = b.pmem_wdata[8*k +: 8];
        end
      end
    end
  end
  always @(negedge clk) begin
    if (!b.mem_resp) chk("rdata_idle", b.mem_rdata, 0);
    if (!b.pmem_write) chk("bsel_idle", b.pmem_byte_sel, 0);
    chk("rd_wr_excl", b.pmem_read & b.pmem_write, 0);
    if (!reset_n) begin
      chk("rst_resp", b.mem_resp, 0);
      chk("rst_pread", b.pmem_read, 0);
      chk("rst_pwrite", b.pmem_write, 0);
    end
    if (b.mem_resp) begin
      resp_seen++;
      chk("resp_pending", pending, 1);
      if (pending && is_rd) chk("resp_rdata", b.mem_rdata, exp_rd);
    end
    if (b.pmem_write) begin
      chk("pwr_bsel", b.pmem_byte_sel, exp_sel);
      chk("pwr_wdata", b.pmem_wdata, {8{b.mem_wdata}});
      chk("pwr_addr", b.pmem_address, b.mem_address);
    end
    if (b.pmem_read) chk("prd_addr", b.pmem_address, b.mem_address);
  end
  task automatic do_read(input logic [11:0] a, input logic [3:0] o, input int la, output logic [15:0] rd, output int lat);
    logic hit;
    hit = mvalid[a[2:0]] && mtag[a[2:0]] == a[11:3];
    arb_lat = la;
    exp_rd = ref_mem[a][16*int'(o[3:1]) +: 16];
    b.mem_read = 1'b1;
    b.mem_write = 1'b0;
    b.mem_address = a;
    b.line_offset = o;
    b.mem_byte_enable = 2'($urandom);
    b.mem_wdata = 16'($urandom);
    pending = 1'b1;
    is_rd = 1'b1;
    resp_exp++;
    lat = -1;
    rd = '0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (b.mem_resp) begin
        lat = c;
        rd = b.mem_rdata;
        break;
      end
    end
    chk("rd_latency", lat, hit ? 0 : la + 1);
    chk("rd_data", rd, exp_rd);
    if (hit) hits++;
    else begin
      misses++;
      mvalid[a[2:0]] = 1'b1;
      mtag[a[2:0]] = a[11:3];
    end
    @(posedge clk);
    #1;
    b.mem_read = 1'b0;
    pending = 1'b0;
  endtask
  task automatic do_write(input logic [11:0] a, input logic [3:0] o, input logic [1:0] be, input logic [15:0] d,
                          input int la, input logic both, output logic [15:0] sel_seen, output int lat);
    int wi;
    wi = int'(o[3:1]);
    arb_lat = la;
    exp_sel = '0;
    exp_sel[2*wi] = be[0];
    exp_sel[2*wi+1] = be[1];
    b.mem_write = 1'b1;
    b.mem_read = both;
    b.mem_address = a;
    b.line_offset = o;
    b.mem_byte_enable = be;
    b.mem_wdata = d;
    pending = 1'b1;
    is_rd = 1'b0;
    resp_exp++;
    lat = -1;
    sel_seen = '0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      chk("wr_no_fill", b.pmem_read, 0);
      if (b.pmem_write) sel_seen = b.pmem_byte_sel;
      if (b.mem_resp) begin
        lat = c;
        break;
      end
    end
    chk("wr_latency", lat, la);
    if (be[0]) ref_mem[a][16*wi +: 8] = d[7:0];
    if (be[1]) ref_mem[a][16*wi+8 +: 8] = d[15:8];
    @(posedge clk);
    #1;
    b.mem_write = 1'b0;
    b.mem_read = 1'b0;
    pending = 1'b0;
  endtask
  initial begin
    #600000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [15:0] rd, sel;
    int lat, s;
    for (int i = 0; i < 4096; i++) begin
      mem[i] = {$urandom, $urandom, $urandom, $urandom};
      ref_mem[i] = mem[i];
    end
    mem[12'h012][47:32] = 16'hBEEF;
    ref_mem[12'h012][47:32] = 16'hBEEF;
    for (int i = 0; i < 8; i++) begin
      mvalid[i] = 1'b0;
      mtag[i] = '0;
    end
    b.mem_read = 1'b0;
    b.mem_write = 1'b0;
    b.mem_address = '0;
    b.line_offset = '0;
    b.mem_byte_enable = '0;
    b.mem_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    do_read(12'h012, 4'd4, 5, rd, lat);
    chk("miss_lat_lit", lat, 6);
    chk("miss_data_lit", rd, 16'hBEEF);
    do_read(12'h012, 4'd4, 5, rd, lat);
    chk("hit_lat_lit", lat, 0);
    do_write(12'h012, 4'd4, 2'b10, 16'h1200, 3, 1'b0, sel, lat);
    chk("wr_bsel_lit", sel, 16'h0020);
    do_read(12'h012, 4'd4, 2, rd, lat);
    chk("merge_lit", rd, 16'h12EF);
    chk("merge_hit_lit", lat, 0);
    do_read(12'h01A, 4'd0, 2, rd, lat);
    chk("conflict_lat_lit", lat, 3);
    do_read(12'h012, 4'd4, 2, rd, lat);
    chk("evicted_lat_lit", lat, 3);
    chk("refill_lit", rd, 16'h12EF);
    s = resp_seen;
    do_read(12'h031, 4'd6, 4, rd, lat);
    do_read(12'h012, 4'd4, 4, rd, lat);
    @(negedge clk);
    chk("ldi_pulses_lit", resp_seen - s, 2);
    arb_lat = 20;
    b.mem_read = 1'b1;
    b.mem_address = 12'h055;
    b.line_offset = 4'd0;
    repeat (3) @(negedge clk);
    chk("fill_pread", b.pmem_read, 1);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    b.mem_read = 1'b0;
    @(negedge clk);
    chk("rstfill_pread", b.pmem_read, 0);
    chk("rstfill_resp", b.mem_resp, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) mvalid[i] = 1'b0;
    hits = 0;
    misses = 0;
    do_read(12'h055, 4'd2, 3, rd, lat);
    chk("rstfill_miss_lit", lat, 4);
    do_read(12'h012, 4'd4, 1, rd, lat);
    chk("rst_inval_lit", lat, 2);
    for (int n = 0; n < 300; n++) begin
      logic [11:0] a;
      logic [3:0] o;
      a = 12'($urandom_range(0, 63));
      o = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 9) < 3)
        do_write(a, o, 2'($urandom), 16'($urandom), $urandom_range(1, 6), 1'($urandom), sel, lat);
      else
        do_read(a, o, $urandom_range(1, 6), rd, lat);
    end
    @(negedge clk);
    chk("resp_count", resp_seen, resp_exp);
`ifdef L1D_PERF_COUNTERS_EN
    chk("hit_count", hit_count, 16'(hits));
    chk("miss_count", miss_count, 16'(misses));
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
